// File: rtl/iz_param_loader_if.sv
// Parameter-load bus between an upstream byte source and iz_param_loader.
// Carries the 8-bit valid/ready byte stream plus the committed parameter set,
// the sticky params_ready flag and the frame_done/frame_error pulses.
// Ports: master = byte source / parameter consumer, slave = the loader.
interface iz_param_loader_if;
    logic [7:0]         load_data;
    logic               load_valid;
    logic               load_ready;
    logic signed [15:0] param_a;
    logic signed [15:0] param_b;
    logic signed [15:0] param_c;
    logic signed [15:0] param_d;
    logic               params_ready;
    logic               frame_done;
    logic               frame_error;

    modport master (
        output load_data, load_valid,
        input  load_ready, param_a, param_b, param_c, param_d,
        input  params_ready, frame_done, frame_error
    );

    modport slave (
        input  load_data, load_valid,
        output load_ready, param_a, param_b, param_c, param_d,
        output params_ready, frame_done, frame_error
    );
endinterface

// File: rtl/iz_param_loader.sv
// Byte-serial a/b/c/d parameter loader feeding the Izhikevich neuron core.
// Latency: params visible one cycle after the last frame byte is accepted (COMMIT cycle).
// Backpressure: load_ready drops only during the single COMMIT cycle.
//
// Ports: i_clk (rising edge), i_reset (synchronous, active-low),
//        bus (iz_param_loader_if.slave): load_data/load_valid/load_ready byte
//        stream in; param_a..param_d, params_ready, frame_done, frame_error out.
// Frame: SYNC_BYTE, a_hi, a_lo, b_hi, b_lo, c_hi, c_lo, d_hi, d_lo.
// Optional macro IZ_LOADER_CHECKSUM_EN: adds a trailing XOR-of-data checksum byte;
// a mismatch aborts the frame with frame_error.
module iz_param_loader #(
    parameter logic [7:0]         SYNC_BYTE      = 8'hA5,
    parameter int                 TIMEOUT_CYCLES = 255,
    parameter logic signed [15:0] DEF_A          = 16'sd1,
    parameter logic signed [15:0] DEF_B          = 16'sd13,
    parameter logic signed [15:0] DEF_C          = -16'sd4160,
    parameter logic signed [15:0] DEF_D          = 16'sd512
) (
    input  logic               i_clk,
    input  logic               i_reset,
    iz_param_loader_if.slave   bus
);

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_COMMIT
    } state_t;

    state_t             r_state;
    logic [7:0]         r_shadow [0:7];
    logic [3:0]         r_byte_cnt;
    logic [15:0]        r_timer;
    logic               r_load_ready;
    logic               r_params_ready;
    logic               r_frame_done;
    logic               r_frame_error;
    logic signed [15:0] r_param_a;
    logic signed [15:0] r_param_b;
    logic signed [15:0] r_param_c;
    logic signed [15:0] r_param_d;
`ifdef IZ_LOADER_CHECKSUM_EN
    logic [7:0]         r_xor;
`endif

    logic w_xfer;
    assign w_xfer = bus.load_valid && r_load_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state        <= S_IDLE;
            r_byte_cnt     <= 4'd0;
            r_timer        <= 16'd0;
            r_load_ready   <= 1'b1;
            r_params_ready <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_error  <= 1'b0;
            r_param_a      <= DEF_A;
            r_param_b      <= DEF_B;
            r_param_c      <= DEF_C;
            r_param_d      <= DEF_D;
            for (int k = 0; k < 8; k++) begin
                r_shadow[k] <= 8'h00;
            end
`ifdef IZ_LOADER_CHECKSUM_EN
            r_xor          <= 8'h00;
`endif
        end else begin
            // Pulses are single-cycle by default; set below only on the event edge.
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_load_ready <= 1'b1;
                    // Anything other than the sync marker is line noise here.
                    if (w_xfer && (bus.load_data == SYNC_BYTE)) begin
                        r_state    <= S_RECV;
                        r_byte_cnt <= 4'd0;
                        r_timer    <= 16'd0;
`ifdef IZ_LOADER_CHECKSUM_EN
                        r_xor      <= 8'h00;
`endif
                    end
                end

                S_RECV: begin
                    if (w_xfer) begin
                        // A sync-valued byte inside a frame is ordinary data.
                        r_timer <= 16'd0;
`ifdef IZ_LOADER_CHECKSUM_EN
                        if (r_byte_cnt == 4'd8) begin
                            if (bus.load_data == r_xor) begin
                                r_state      <= S_COMMIT;
                                r_load_ready <= 1'b0;
                            end else begin
                                r_state       <= S_IDLE;
                                r_frame_error <= 1'b1;
                            end
                        end else begin
                            r_shadow[r_byte_cnt[2:0]] <= bus.load_data;
                            r_xor                     <= r_xor ^ bus.load_data;
                            r_byte_cnt                <= r_byte_cnt + 4'd1;
                        end
`else
                        r_shadow[r_byte_cnt[2:0]] <= bus.load_data;
                        r_byte_cnt                <= r_byte_cnt + 4'd1;
                        if (r_byte_cnt == 4'd7) begin
                            r_state      <= S_COMMIT;
                            r_load_ready <= 1'b0;
                        end
`endif
                    end else if (r_timer == TIMEOUT_W) begin
                        // Stalled frame: drop it, committed params untouched.
                        r_state       <= S_IDLE;
                        r_frame_error <= 1'b1;
                        r_timer       <= 16'd0;
                        r_byte_cnt    <= 4'd0;
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_COMMIT: begin
                    // All four words and the flags move on one edge so the core
                    // never observes a half-updated parameter set.
                    r_param_a      <= {r_shadow[0], r_shadow[1]};
                    r_param_b      <= {r_shadow[2], r_shadow[3]};
                    r_param_c      <= {r_shadow[4], r_shadow[5]};
                    r_param_d      <= {r_shadow[6], r_shadow[7]};
                    r_params_ready <= 1'b1;
                    r_frame_done   <= 1'b1;
                    r_load_ready   <= 1'b1;
                    r_byte_cnt     <= 4'd0;
                    r_state        <= S_IDLE;
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_load_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.load_ready   = r_load_ready;
    assign bus.param_a      = r_param_a;
    assign bus.param_b      = r_param_b;
    assign bus.param_c      = r_param_c;
    assign bus.param_d      = r_param_d;
    assign bus.params_ready = r_params_ready;
    assign bus.frame_done   = r_frame_done;
    assign bus.frame_error  = r_frame_error;

endmodule

// File: tb/tb_iz_param_loader.sv
// Directed bench for iz_param_loader: reset defaults, commit timing, sync
// filtering, in-frame sync data, timeout abort, mid-frame reset and (when
// IZ_LOADER_CHECKSUM_EN is defined) checksum accept/reject.
module tb_iz_param_loader;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    iz_param_loader_if bus ();

    iz_param_loader #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitors.
    int done_cnt = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(posedge clk) begin
        if (bus.frame_done)                    done_cnt++;
        if (bus.frame_error)                   err_cnt++;
        if (bus.frame_done && bus.frame_error) both_cnt++;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        bus.load_data  = b;
        bus.load_valid = 1'b1;
        while (!bus.load_ready && w < 8) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 8) check("ready_wait", {15'd0, bus.load_ready}, 16'd1);
        @(posedge clk); #1;
        bus.load_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d,
                              input logic bad_ck);
        logic [7:0] ck;
        ck = a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0] ^ c[15:8] ^ c[7:0] ^ d[15:8] ^ d[7:0];
        send_byte(8'hA5);
        send_byte(a[15:8]); send_byte(a[7:0]);
        send_byte(b[15:8]); send_byte(b[7:0]);
        send_byte(c[15:8]); send_byte(c[7:0]);
        send_byte(d[15:8]); send_byte(d[7:0]);
`ifdef IZ_LOADER_CHECKSUM_EN
        send_byte(bad_ck ? (ck ^ 8'h01) : ck);
`else
        if (bad_ck) ck = 8'h00;
`endif
    endtask

    task automatic check_params(input string tag, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] c, input logic [15:0] d);
        check({tag, "_a"}, bus.param_a, a);
        check({tag, "_b"}, bus.param_b, b);
        check({tag, "_c"}, bus.param_c, c);
        check({tag, "_d"}, bus.param_d, d);
    endtask

    // Called #1 after the edge accepting the final byte: verify COMMIT cycle,
    // then params + frame_done one edge later, then frame_done drops.
    task automatic expect_commit(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] c, input logic [15:0] d);
        check({tag, "_commit_rdy"},  {15'd0, bus.load_ready}, 16'd0);
        check({tag, "_commit_done"}, {15'd0, bus.frame_done}, 16'd0);
        @(posedge clk); #1;
        check_params(tag, a, b, c, d);
        check({tag, "_pready"}, {15'd0, bus.params_ready}, 16'd1);
        check({tag, "_done"},   {15'd0, bus.frame_done},   16'd1);
        check({tag, "_rdy"},    {15'd0, bus.load_ready},   16'd1);
        @(posedge clk); #1;
        check({tag, "_done_end"}, {15'd0, bus.frame_done}, 16'd0);
    endtask

    initial begin
        int n;
        int d0;
        int e0;
        bus.load_data  = 8'h00;
        bus.load_valid = 1'b0;

        // 1. reset defaults
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_params("rst", 16'h0001, 16'h000D, 16'hEFC0, 16'h0200);
        check("rst_pready", {15'd0, bus.params_ready}, 16'd0);
        check("rst_rdy",    {15'd0, bus.load_ready},   16'd1);
        check("rst_done",   {15'd0, bus.frame_done},   16'd0);

        // 2. first frame, back-to-back
        send_frame(16'h0002, 16'h000D, 16'hEFC0, 16'h0080, 1'b0);
        expect_commit("f1", 16'h0002, 16'h000D, 16'hEFC0, 16'h0080);

        // 3. noise before sync, then sync value as data
        send_byte(8'h3C);
        send_byte(8'h11);
        check("noise_rdy", {15'd0, bus.load_ready}, 16'd1);
        send_frame(16'h1234, 16'hFFFF, 16'h8000, 16'h0001, 1'b0);
        expect_commit("f2", 16'h1234, 16'hFFFF, 16'h8000, 16'h0001);
        send_frame(16'hA5A5, 16'h00A5, 16'hA500, 16'h7FFF, 1'b0);
        expect_commit("f3", 16'hA5A5, 16'h00A5, 16'hA500, 16'h7FFF);
        check("done_cnt3", 16'(done_cnt), 16'd3);
        check("err_cnt3",  16'(err_cnt),  16'd0);

        // 4. timeout after 3 data bytes (TIMEOUT_CYCLES=16)
        send_byte(8'hA5);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        n = 0;
        while (!bus.frame_error && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("timeout_lat", 16'(n), 16'd17);
        check("timeout_done", {15'd0, bus.frame_done}, 16'd0);
        @(posedge clk); #1;
        check("timeout_pulse_end", {15'd0, bus.frame_error}, 16'd0);
        check_params("to_keep", 16'hA5A5, 16'h00A5, 16'hA500, 16'h7FFF);
        check("to_pready", {15'd0, bus.params_ready}, 16'd1);
        check("err_cnt4",  16'(err_cnt),  16'd1);
        send_frame(16'h0003, 16'h0010, 16'hF000, 16'h0100, 1'b0);
        expect_commit("f4", 16'h0003, 16'h0010, 16'hF000, 16'h0100);

        // 5. reset after 5 data bytes
        send_byte(8'hA5);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h44); send_byte(8'h55);
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check_params("mid_rst", 16'h0001, 16'h000D, 16'hEFC0, 16'h0200);
        check("mid_rst_pready", {15'd0, bus.params_ready}, 16'd0);
        check("mid_rst_rdy",    {15'd0, bus.load_ready},   16'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(16'h0055, 16'h0066, 16'hFF77, 16'h0088, 1'b0);
        expect_commit("f5", 16'h0055, 16'h0066, 16'hFF77, 16'h0088);

`ifdef IZ_LOADER_CHECKSUM_EN
        // 6. checksum good then corrupted
        send_frame(16'h0F0F, 16'h00F0, 16'hC3C3, 16'h0101, 1'b0);
        expect_commit("ck_ok", 16'h0F0F, 16'h00F0, 16'hC3C3, 16'h0101);
        d0 = done_cnt;
        e0 = err_cnt;
        send_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("ck_bad_err",  16'(err_cnt - e0),  16'd1);
        check("ck_bad_done", 16'(done_cnt - d0), 16'd0);
        check_params("ck_bad_keep", 16'h0F0F, 16'h00F0, 16'hC3C3, 16'h0101);
`else
        d0 = done_cnt;
        e0 = err_cnt;
        check("tot_done", 16'(d0), 16'd5);
        check("tot_err",  16'(e0), 16'd1);
`endif
        check("pulse_overlap", 16'(both_cnt), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
